tsc_rx: RTL and testbench

Host-side receiver and sequencer for the trigger/serial-capture (TSC) link. It arms the capture unit, waits for its trigger-done flag, and requests the buffer dump. It then deserializes the framed bit stream on SD into bytes, presenting each as a one-cycle strobe to downstream logic. It sits between the TSC capture block and the host logic/FIFO, on the same clock as the capture block.

---
 rtl/tsc_pkg.sv | 28 ++
 rtl/tsc_rx_if.sv | 33 +++
 rtl/tsc_rx_shift.sv | 43 ++++
 rtl/tsc_rx.sv | 160 ++++++++++++++++
 tb/tb_tsc_rx.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tsc_pkg.sv
// tsc_pkg: definitions shared by the TSC receiver and the capture block.
//   rx_state_t    - receiver sequencer states
//   err_code_t    - values reported on the err output
//   START_LEVEL   - SD level of a frame start bit
//   BITS_PER_BYTE - data bits per frame, MSB first
package tsc_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    REQ   = 3'd2,
    HUNT  = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } rx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_TRD_TO = 2'd1,
    ERR_SD_TO  = 2'd2,
    ERR_OVF    = 2'd3
  } err_code_t;

  localparam logic START_LEVEL   = 1'b1;
  localparam int   BITS_PER_BYTE = 8;

endpackage

// File: rtl/tsc_rx_if.sv
// tsc_rx_if: signals between the TSC receiver, the capture block and host.
//   go, TRD, CD, SD        - host command and capture-block levels/data
//   start, SBF             - one-cycle pulses towards the capture block
//   byte_data, byte_valid  - received byte and its one-cycle strobe
//   byte_count, busy, done, err - sequence status towards the host
// master: the side driving go/TRD/CD/SD; slave: the receiver itself.
interface tsc_rx_if;
  import tsc_pkg::*;

  logic                     go;
  logic                     TRD;
  logic                     CD;
  logic                     SD;
  logic                     start;
  logic                     SBF;
  logic [BITS_PER_BYTE-1:0] byte_data;
  logic                     byte_valid;
  logic [5:0]               byte_count;
  logic                     busy;
  logic                     done;
  logic [1:0]               err;

  modport master (
    output go, TRD, CD, SD,
    input  start, SBF, byte_data, byte_valid, byte_count, busy, done, err
  );

  modport slave (
    input  go, TRD, CD, SD,
    output start, SBF, byte_data, byte_valid, byte_count, busy, done, err
  );

endinterface

// File: rtl/tsc_rx_shift.sv
// tsc_rx_shift: MSB-first serial-to-parallel converter with a bit counter.
//   clk, reset  - clock and synchronous active-low reset
//   clear       - restart the bit counter (start bit seen)
//   shift_en    - shift sd in this cycle
//   sd          - serial data bit
//   byte_next   - shift register contents including the current sd bit
//   byte_ready  - the bit shifted in this cycle completes the byte
module tsc_rx_shift
  import tsc_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     shift_en,
  input  logic                     sd,
  output logic [BITS_PER_BYTE-1:0] byte_next,
  output logic                     byte_ready
);

  localparam int CW = $clog2(BITS_PER_BYTE);

  logic [BITS_PER_BYTE-1:0] shift_reg;
  logic [CW-1:0]            bit_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
    end else if (clear) begin
      bit_cnt_reg <= '0;
    end else if (shift_en) begin
      shift_reg   <= byte_next;
      bit_cnt_reg <= bit_cnt_reg + CW'(1);
    end
  end

  assign byte_next = {shift_reg[BITS_PER_BYTE-2:0], sd};

  // Depends on the counter only, so the sequencer can gate it with its own
  // state without forming a combinational loop through shift_en.
  assign byte_ready = (bit_cnt_reg == CW'(BITS_PER_BYTE - 1));

endmodule

// File: rtl/tsc_rx.sv
// tsc_rx: host-side sequencer and frame receiver for the TSC link.
// Arms the capture block (start), waits for TRD, requests the dump (SBF),
// then deserializes start-bit framed bytes on SD until CD ends the dump.
//   clk, reset - clock and synchronous active-low reset
//   bus        - tsc_rx_if slave port (inputs go/TRD/CD/SD, outputs
//                start/SBF/byte_data/byte_valid/byte_count/busy/done/err)
// Parameters: MAX_BYTES bytes accepted per dump, TIMEOUT_CYC wait limit.
module tsc_rx
  import tsc_pkg::*;
#(
  parameter int MAX_BYTES   = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic    clk,
  input  logic    reset,
  tsc_rx_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYC);
  localparam logic [5:0]    COUNT_MAX = 6'(MAX_BYTES);

  rx_state_t                state_reg, state_next;
  logic [TW-1:0]            timer_reg, timer_next, timer_inc;
  logic                     start_reg, start_next;
  logic                     sbf_reg, sbf_next;
  logic [BITS_PER_BYTE-1:0] byte_data_reg, byte_data_next;
  logic                     byte_valid_reg, byte_valid_next;
  logic [5:0]               byte_count_reg, byte_count_next;
  logic                     done_reg, done_next;
  err_code_t                err_reg, err_next;

  logic                     sh_clear, sh_en, sh_ready;
  logic [BITS_PER_BYTE-1:0] sh_byte;

  tsc_rx_shift u_shift (
    .clk       (clk),
    .reset     (reset),
    .clear     (sh_clear),
    .shift_en  (sh_en),
    .sd        (bus.SD),
    .byte_next (sh_byte),
    .byte_ready(sh_ready)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      timer_reg      <= '0;
      start_reg      <= 1'b0;
      sbf_reg        <= 1'b0;
      byte_data_reg  <= '0;
      byte_valid_reg <= 1'b0;
      byte_count_reg <= '0;
      done_reg       <= 1'b0;
      err_reg        <= ERR_NONE;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      start_reg      <= start_next;
      sbf_reg        <= sbf_next;
      byte_data_reg  <= byte_data_next;
      byte_valid_reg <= byte_valid_next;
      byte_count_reg <= byte_count_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
    end
  end

  // The timer only runs in the two waiting states; every other state clears
  // it, so entering ARM or HUNT always starts the wait from zero.
  always_comb begin
    state_next      = state_reg;
    timer_next      = '0;
    timer_inc       = (timer_reg == TIMER_MAX) ? timer_reg : timer_reg + TW'(1);
    start_next      = 1'b0;
    sbf_next        = 1'b0;
    byte_data_next  = byte_data_reg;
    byte_valid_next = 1'b0;
    byte_count_next = byte_count_reg;
    done_next       = done_reg;
    err_next        = err_reg;
    sh_clear        = 1'b0;
    sh_en           = 1'b0;

    case (state_reg)
      IDLE, DONE, ERR: begin
        if (bus.go) begin
          state_next      = ARM;
          start_next      = 1'b1;
          done_next       = 1'b0;
          err_next        = ERR_NONE;
          byte_count_next = '0;
        end
      end
      ARM: begin
        if (bus.TRD) begin
          state_next = REQ;
          sbf_next   = 1'b1;
        end else if (timer_reg == TIMER_MAX) begin
          state_next = ERR;
          err_next   = ERR_TRD_TO;
        end else begin
          timer_next = timer_inc;
        end
      end
      REQ: begin
        state_next = HUNT;
      end
      HUNT: begin
        // A start bit beats CD: CD only means something between frames.
        if (bus.SD == START_LEVEL) begin
          state_next = SHIFT;
          sh_clear   = 1'b1;
        end else if (bus.CD) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else if (timer_reg == TIMER_MAX) begin
          state_next = ERR;
          err_next   = ERR_SD_TO;
        end else begin
          timer_next = timer_inc;
        end
      end
      SHIFT: begin
        if (bus.CD) begin
          // Dump ended inside a frame: the partial byte is dropped.
          state_next = ERR;
          err_next   = ERR_OVF;
        end else begin
          sh_en = 1'b1;
          if (sh_ready) begin
            if (byte_count_reg == COUNT_MAX) begin
              state_next = ERR;
              err_next   = ERR_OVF;
            end else begin
              state_next      = HUNT;
              byte_data_next  = sh_byte;
              byte_valid_next = 1'b1;
              byte_count_next = byte_count_reg + 6'd1;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.start      = start_reg;
  assign bus.SBF        = sbf_reg;
  assign bus.byte_data  = byte_data_reg;
  assign bus.byte_valid = byte_valid_reg;
  assign bus.byte_count = byte_count_reg;
  assign bus.busy       = (state_reg != IDLE) && (state_reg != DONE) && (state_reg != ERR);
  assign bus.done       = done_reg;
  assign bus.err        = err_reg;

endmodule

// File: tb/tb_tsc_rx.sv
// tb_tsc_rx: randomized scoreboard bench for tsc_rx.
// Stimulus tasks push expected start/SBF/byte events into queues; a monitor
// on the falling edge pops and compares them whenever the DUT pulses.
module tb_tsc_rx;

  localparam int MAXB = 32;
  localparam int TO   = 16;

  localparam int MODE_CLEAN = 0;  // dump ends with CD
  localparam int MODE_TRUNC = 1;  // CD raised 4 data bits into the last frame
  localparam int MODE_OVF   = 2;  // more than MAXB frames
  localparam int MODE_SDTO  = 3;  // stream stops after the last frame
  localparam int MODE_RST   = 4;  // reset after 5 data bits of the last frame

  logic clk = 1'b0;
  logic reset = 1'b0;

  tsc_rx_if bus ();

  tsc_rx #(.MAX_BYTES(MAXB), .TIMEOUT_CYC(TO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         count;
    int         at;
  } byte_exp_t;

  int        start_q[$];
  int        sbf_q[$];
  byte_exp_t byte_q[$];
  logic [7:0] tx_bytes[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT pulse must match the oldest expected event.
  always @(negedge clk) begin
    byte_exp_t e;
    if (reset) begin
      if (bus.start) begin
        if (start_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL start_unexpected: got pulse at cycle %0d required none", cyc);
        end else check("start_cycle", cyc, start_q.pop_front());
      end
      if (bus.SBF) begin
        if (sbf_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sbf_unexpected: got pulse at cycle %0d required none", cyc);
        end else check("sbf_cycle", cyc, sbf_q.pop_front());
      end
      if (bus.byte_valid) begin
        if (byte_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL byte_unexpected: got 0x%02h at cycle %0d required none", bus.byte_data, cyc);
        end else begin
          e = byte_q.pop_front();
          check("byte_data", int'(bus.byte_data), int'(e.data));
          check("byte_count", int'(bus.byte_count), e.count);
          check("byte_cycle", cyc, e.at);
          $display("byte 0x%02h count %0d at cycle %0d", bus.byte_data, bus.byte_count, cyc);
        end
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_start", int'(bus.start), 0);
    check("rst_sbf", int'(bus.SBF), 0);
    check("rst_byte_data", int'(bus.byte_data), 0);
    check("rst_byte_valid", int'(bus.byte_valid), 0);
    check("rst_byte_count", int'(bus.byte_count), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
  endtask

  task automatic drain_queues();
    tick(); tick();
    check("start_pending", start_q.size(), 0);
    check("sbf_pending", sbf_q.size(), 0);
    check("bytes_pending", byte_q.size(), 0);
    start_q.delete(); sbf_q.delete(); byte_q.delete();
  endtask

  task automatic fill_random(input int n);
    tx_bytes.delete();
    for (int i = 0; i < n; i++) tx_bytes.push_back(8'($urandom_range(255)));
  endtask

  task automatic run_dump(input int trd_delay, input int mode, input bit rand_gap);
    int n = tx_bytes.size();
    int got = 0;
    int c, hunt_entry, guard;
    logic [7:0] last_ok = 8'h00;

    bus.go = 1'b1;
    start_q.push_back(cyc + 1);
    tick();
    bus.go = 1'b0;
    check("go_busy", int'(bus.busy), 1);
    check("go_done_clr", int'(bus.done), 0);
    check("go_err_clr", int'(bus.err), 0);
    check("go_count_clr", int'(bus.byte_count), 0);

    repeat (trd_delay - 1) tick();
    bus.TRD = 1'b1;
    sbf_q.push_back(cyc + 1);
    tick(); tick();
    if (rand_gap) repeat ($urandom_range(3)) tick();

    for (int i = 0; i < n; i++) begin
      c = cyc;
      bus.SD = 1'b1;
      // Start bit with CD in the same cycle: the frame must still be taken.
      if (i == 0 && mode == MODE_CLEAN && rand_gap) bus.CD = 1'b1;
      tick();
      bus.CD = 1'b0;
      if (i == n - 1 && mode == MODE_TRUNC) begin
        for (int b = 7; b >= 4; b--) begin bus.SD = tx_bytes[i][b]; tick(); end
        bus.SD = 1'($urandom_range(1));
        bus.CD = 1'b1;
        tick();
        bus.CD = 1'b0;
        bus.SD = 1'b0;
        break;
      end
      if (i == n - 1 && mode == MODE_RST) begin
        for (int b = 7; b >= 3; b--) begin bus.SD = tx_bytes[i][b]; tick(); end
        reset = 1'b0;
        bus.SD = 1'b0;
        bus.TRD = 1'b0;
        tick();
        check_reset_outputs();
        reset = 1'b1;
        drain_queues();
        return;
      end
      if (got < MAXB) begin
        byte_q.push_back('{tx_bytes[i], got + 1, c + 9});
        got++;
        last_ok = tx_bytes[i];
      end
      for (int b = 7; b >= 0; b--) begin bus.SD = tx_bytes[i][b]; tick(); end
      bus.SD = 1'b0;
      if (rand_gap && i != n - 1) repeat ($urandom_range(3)) tick();
    end

    case (mode)
      MODE_CLEAN: begin
        check("pre_cd_done", int'(bus.done), 0);
        bus.CD = 1'b1;
        tick();
        bus.CD = 1'b0;
        check("end_done", int'(bus.done), 1);
        check("end_busy", int'(bus.busy), 0);
        check("end_err", int'(bus.err), 0);
        check("end_count", int'(bus.byte_count), got);
        check("end_byte_data", int'(bus.byte_data), int'(last_ok));
      end
      MODE_TRUNC, MODE_OVF: begin
        check("err_code", int'(bus.err), 3);
        check("err_busy", int'(bus.busy), 0);
        check("err_done", int'(bus.done), 0);
        check("err_count", int'(bus.byte_count), got);
      end
      default: begin
        hunt_entry = cyc;
        guard = 0;
        while (bus.err == 2'd0 && guard < 60) begin tick(); guard++; end
        check("sdto_cycle", cyc, hunt_entry + TO + 1);
        check("sdto_code", int'(bus.err), 2);
        check("sdto_busy", int'(bus.busy), 0);
        check("sdto_count", int'(bus.byte_count), got);
      end
    endcase
    bus.TRD = 1'b0;
    drain_queues();
  endtask

  task automatic trd_timeout();
    int g, guard;
    g = cyc;
    bus.go = 1'b1;
    start_q.push_back(g + 1);
    tick();
    bus.go = 1'b0;
    guard = 0;
    while (bus.err == 2'd0 && guard < 60) begin tick(); guard++; end
    check("trdto_cycle", cyc, g + TO + 2);
    check("trdto_code", int'(bus.err), 1);
    check("trdto_busy", int'(bus.busy), 0);
    drain_queues();
  endtask

  initial begin
    bus.go = 1'b0; bus.TRD = 1'b0; bus.CD = 1'b0; bus.SD = 1'b0;
    reset = 1'b0;
    tick(); tick();
    check_reset_outputs();
    reset = 1'b1;
    tick();

    tx_bytes.delete();
    tx_bytes.push_back(8'hD6); tx_bytes.push_back(8'h01); tx_bytes.push_back(8'hFF);
    run_dump(10, MODE_CLEAN, 1'b0);

    fill_random(4);
    run_dump($urandom_range(8, 3), MODE_CLEAN, 1'b1);

    trd_timeout();

    tx_bytes.delete();
    for (int i = 0; i < MAXB + 1; i++) tx_bytes.push_back(8'hA5);
    run_dump(5, MODE_OVF, 1'b0);

    fill_random(MAXB);
    run_dump(4, MODE_CLEAN, 1'b1);

    fill_random(2);
    run_dump(6, MODE_TRUNC, 1'b1);

    fill_random(2);
    run_dump(3, MODE_SDTO, 1'b1);

    fill_random(2);
    run_dump(3, MODE_RST, 1'b0);
    tx_bytes.delete();
    tx_bytes.push_back(8'h3C);
    run_dump(4, MODE_CLEAN, 1'b0);

    for (int r = 0; r < 3; r++) begin
      fill_random($urandom_range(6, 1));
      run_dump($urandom_range(12, 2), MODE_CLEAN, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by cycle %0d required finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
